// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder with scan mode.
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Bits needed to count 0..v-1, never less than one so DWELL=1 still has a flop.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(v)) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell timer: counts 0..DWELL-1 while run is high and flags the last count.
module dwell_counter
    import decoder_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned   CW   = clog2_min1(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with direct and dwell-timed scan modes.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int unsigned N          = 3,
    parameter int unsigned DWELL      = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      in,
    input  logic              load,
    output logic [2**N-1:0]   out,
    output logic [N-1:0]      idx,
    output logic              valid,
    output logic              wrap
);

    localparam int unsigned     OUTS     = 2**N;
    localparam logic [OUTS-1:0] INACTIVE = {OUTS{ACTIVE_LOW}};
    localparam logic [OUTS-1:0] ONE      = OUTS'(1);

    state_e          state_q, state_d;
    logic [N-1:0]    pos_q, pos_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [OUTS-1:0] out_q, out_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;
    logic            run, clr, tick;

    always_comb begin
        state_d = ST_IDLE;
        if (en) begin
            case (mode)
                MODE_DIRECT: state_d = ST_DIRECT;
                MODE_SCAN:   state_d = ST_SCAN;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // The timer only advances while scan continues; entry, exit and load restart it.
    assign run = (state_q == ST_SCAN) && (state_d == ST_SCAN);
    assign clr = !run || load;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        pos_d   = pos_q;
        idx_d   = idx_q;
        out_d   = INACTIVE;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        case (state_d)
            ST_DIRECT: begin
                idx_d   = in;
                out_d   = (ONE << in) ^ INACTIVE;
                valid_d = 1'b1;
            end
            ST_SCAN: begin
                if (load) begin
                    pos_d = in;
                end else if (tick) begin
                    pos_d  = pos_q + 1'b1;
                    wrap_d = (pos_q == '1);
                end
                idx_d   = pos_d;
                out_d   = (ONE << pos_d) ^ INACTIVE;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            idx_q   <= '0;
            out_q   <= INACTIVE;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out   = out_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule
